tx_input_buffer: RTL and testbench

Single-clock, parametrised width-down-converting FIFO for the transmitter input path. Accepts words of IN_WIDTH bits and delivers them as RATIO narrower words of IN_WIDTH/RATIO bits, in a selectable slice order. Raises a registered ready flag once a programmable fill level is reached, and reports fill level, full/empty and sticky overflow/underflow status. Sits between the sample source and the transmitter framer; the framer drains it.

---
 rtl/tx_input_buffer_if.sv | 31 +++
 rtl/tx_input_buffer.sv | 114 +++++++++++
 tb/tb_tx_input_buffer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_input_buffer_if.sv
// Bus bundle for tx_input_buffer: write/read request strobes, data and fill status.
// Both requests are single-cycle strobes with no ready back-pressure; a request is accepted
// when write_req && !full or read_req && !empty at the sampling edge, otherwise overflow/underflow is set.
interface tx_input_buffer_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int UW        = 7
);
  logic                 flush;
  logic                 write_req;
  logic [IN_WIDTH-1:0]  input_data;
  logic                 read_req;
  logic [OUT_WIDTH-1:0] output_data;
  logic                 output_valid;
  logic                 input_ready;
  logic [UW-1:0]        used_w;
  logic                 empty;
  logic                 full;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output flush, write_req, input_data, read_req,
    input  output_data, output_valid, input_ready, used_w, empty, full, overflow, underflow
  );

  modport slave (
    input  flush, write_req, input_data, read_req,
    output output_data, output_valid, input_ready, used_w, empty, full, overflow, underflow
  );
endinterface

// File: rtl/tx_input_buffer.sv
// Width-down-converting FIFO: each IN_WIDTH write stores RATIO slices, each read pops one slice.
// Fill level is counted in output words; input_ready is a registered threshold flag.
module tx_input_buffer #(
  parameter int IN_WIDTH  = 16,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 64,
  parameter int THRESHOLD = 10,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             arst,
  tx_input_buffer_if.slave bus
);
  localparam int OUT_WIDTH = IN_WIDTH / RATIO;
  localparam int AW        = $clog2(DEPTH);
  localparam int UW        = AW + 1;

  logic [OUT_WIDTH-1:0] mem_q [DEPTH];
  logic [OUT_WIDTH-1:0] slice_c [RATIO];

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [UW-1:0]        used_q, used_d;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 ready_q, ready_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic empty_c, full_c, wr_acc, rd_acc;

  // Slice k is the k-th word handed to the reader for one input word.
  for (genvar k = 0; k < RATIO; k++) begin : g_slice
    if (MSB_FIRST != 0) begin : g_msb
      assign slice_c[k] = bus.input_data[IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH];
    end else begin : g_lsb
      assign slice_c[k] = bus.input_data[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign empty_c = (used_q == '0);
  assign full_c  = (used_q > UW'(DEPTH - RATIO));
  assign wr_acc  = bus.write_req && !full_c;
  assign rd_acc  = bus.read_req && !empty_c;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    used_d   = used_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    ready_d  = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      used_d   = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(RATIO);
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        dout_d   = mem_q[rd_ptr_q];
      end
      used_d  = used_q + (wr_acc ? UW'(RATIO) : UW'(0)) - (rd_acc ? UW'(1) : UW'(0));
      valid_d = rd_acc;
      ready_d = (used_d >= UW'(THRESHOLD));
      ovf_d   = ovf_q | (bus.write_req && full_c);
      unf_d   = unf_q | (bus.read_req && empty_c);
    end
  end

  // Storage has no reset; slices of one word never straddle the wrap since DEPTH % RATIO == 0.
  always_ff @(posedge clk) begin
    if (wr_acc && !bus.flush) begin
      for (int k = 0; k < RATIO; k++) begin
        mem_q[wr_ptr_q + AW'(k)] <= slice_c[k];
      end
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.output_data  = dout_q;
  assign bus.output_valid = valid_q;
  assign bus.input_ready  = ready_q;
  assign bus.used_w       = used_q;
  assign bus.empty        = empty_c;
  assign bus.full         = full_c;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_tx_input_buffer.sv
// Bench for tx_input_buffer: default instance (16b, RATIO 2, MSB first) checked by a table plus
// a reference model with a slice queue; a second instance (32b, RATIO 4, LSB first) by hand sequences.
module tb_tx_input_buffer;
  logic clk;
  logic arst;

  tx_input_buffer_if #(.IN_WIDTH(16), .OUT_WIDTH(8), .UW(7)) bus_a ();
  tx_input_buffer_if #(.IN_WIDTH(32), .OUT_WIDTH(8), .UW(7)) bus_b ();

  tx_input_buffer #(.IN_WIDTH(16), .RATIO(2), .DEPTH(64), .THRESHOLD(10), .MSB_FIRST(1)) dut_a (
    .clk(clk), .arst(arst), .bus(bus_a)
  );
  tx_input_buffer #(.IN_WIDTH(32), .RATIO(4), .DEPTH(64), .THRESHOLD(10), .MSB_FIRST(0)) dut_b (
    .clk(clk), .arst(arst), .bus(bus_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model for instance a
  logic [7:0] exp_q[$];
  int         m_used;
  logic       m_valid, m_ready, m_ov, m_uf;
  logic [7:0] m_dout;

  task automatic model_reset();
    exp_q.delete();
    m_used = 0; m_valid = 0; m_ready = 0; m_ov = 0; m_uf = 0; m_dout = 8'h00;
  endtask

  task automatic tick_a();
    logic wacc, racc;
    if (bus_a.flush) begin
      exp_q.delete();
      m_used = 0; m_ov = 0; m_uf = 0; m_valid = 0;
    end else begin
      wacc = bus_a.write_req && (m_used <= 62);
      racc = bus_a.read_req && (m_used != 0);
      if (bus_a.write_req && !wacc) m_ov = 1;
      if (bus_a.read_req && m_used == 0) m_uf = 1;
      m_valid = racc;
      if (wacc) begin
        exp_q.push_back(bus_a.input_data[15:8]);
        exp_q.push_back(bus_a.input_data[7:0]);
      end
      m_used = m_used + (wacc ? 2 : 0) - (racc ? 1 : 0);
    end
    m_ready = !bus_a.flush && (m_used >= 10);
    @(posedge clk); #1;
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_sb_empty: read completed with nothing expected");
      end else begin
        m_dout = exp_q.pop_front();
      end
    end
    chk("a_used",   32'(bus_a.used_w),       32'(m_used));
    chk("a_empty",  32'(bus_a.empty),        32'(m_used == 0));
    chk("a_full",   32'(bus_a.full),         32'(m_used > 62));
    chk("a_ready",  32'(bus_a.input_ready),  32'(m_ready));
    chk("a_valid",  32'(bus_a.output_valid), 32'(m_valid));
    chk("a_dout",   32'(bus_a.output_data),  32'(m_dout));
    chk("a_ovf",    32'(bus_a.overflow),     32'(m_ov));
    chk("a_unf",    32'(bus_a.underflow),    32'(m_uf));
  endtask

  task automatic drive_a(input logic wr, input logic rd, input logic [15:0] din, input logic fl);
    bus_a.write_req  = wr;
    bus_a.read_req   = rd;
    bus_a.input_data = din;
    bus_a.flush      = fl;
  endtask

  task automatic tick_b(input logic wr, input logic rd, input logic [31:0] din);
    bus_b.write_req  = wr;
    bus_b.read_req   = rd;
    bus_b.input_data = din;
    @(posedge clk); #1;
    bus_b.write_req  = 1'b0;
    bus_b.read_req   = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rst_used"},  32'(bus_a.used_w),       32'd0);
    chk({tag, "_rst_empty"}, 32'(bus_a.empty),        32'd1);
    chk({tag, "_rst_full"},  32'(bus_a.full),         32'd0);
    chk({tag, "_rst_ready"}, 32'(bus_a.input_ready),  32'd0);
    chk({tag, "_rst_valid"}, 32'(bus_a.output_valid), 32'd0);
    chk({tag, "_rst_dout"},  32'(bus_a.output_data),  32'd0);
    chk({tag, "_rst_ovf"},   32'(bus_a.overflow),     32'd0);
    chk({tag, "_rst_unf"},   32'(bus_a.underflow),    32'd0);
    chk({tag, "_rstb_used"}, 32'(bus_b.used_w),       32'd0);
    chk({tag, "_rstb_empty"},32'(bus_b.empty),        32'd1);
    chk({tag, "_rstb_full"}, 32'(bus_b.full),         32'd0);
    chk({tag, "_rstb_valid"},32'(bus_b.output_valid), 32'd0);
    chk({tag, "_rstb_dout"}, 32'(bus_b.output_data),  32'd0);
    chk({tag, "_rstb_ready"},32'(bus_b.input_ready),  32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    logic [6:0]  used;
    logic        empty;
    logic        ready;
    logic        valid;
    logic [7:0]  dout;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int accepted;
    int cycles;
    logic [7:0] held;

    vecs[0] = '{1'b1, 1'b0, 16'hA1B2, 7'd2,  1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 7'd1,  1'b0, 1'b0, 1'b1, 8'hA1};
    vecs[2] = '{1'b0, 1'b1, 16'h0000, 7'd0,  1'b1, 1'b0, 1'b1, 8'hB2};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 7'd0,  1'b1, 1'b0, 1'b0, 8'hB2};
    vecs[4] = '{1'b1, 1'b0, 16'h0102, 7'd2,  1'b0, 1'b0, 1'b0, 8'hB2};
    vecs[5] = '{1'b1, 1'b0, 16'h0304, 7'd4,  1'b0, 1'b0, 1'b0, 8'hB2};
    vecs[6] = '{1'b1, 1'b0, 16'h0506, 7'd6,  1'b0, 1'b0, 1'b0, 8'hB2};
    vecs[7] = '{1'b1, 1'b0, 16'h0708, 7'd8,  1'b0, 1'b0, 1'b0, 8'hB2};
    vecs[8] = '{1'b1, 1'b0, 16'h090A, 7'd10, 1'b0, 1'b1, 1'b0, 8'hB2};
    vecs[9] = '{1'b0, 1'b1, 16'h0000, 7'd9,  1'b0, 1'b0, 1'b1, 8'h01};

    arst = 1'b0;
    drive_a(1'b0, 1'b0, 16'h0000, 1'b0);
    bus_b.flush = 1'b0; bus_b.write_req = 1'b0; bus_b.read_req = 1'b0; bus_b.input_data = '0;
    model_reset();
    #2;
    chk_reset("init");
    #20 arst = 1'b1;

    // basic slice order, valid pulses, threshold
    for (int i = 0; i < 10; i++) begin
      drive_a(vecs[i].wr, vecs[i].rd, vecs[i].din, 1'b0);
      tick_a();
      chk($sformatf("vec%0d_used", i),  32'(bus_a.used_w),       32'(vecs[i].used));
      chk($sformatf("vec%0d_empty", i), 32'(bus_a.empty),        32'(vecs[i].empty));
      chk($sformatf("vec%0d_ready", i), 32'(bus_a.input_ready),  32'(vecs[i].ready));
      chk($sformatf("vec%0d_valid", i), 32'(bus_a.output_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_dout", i),  32'(bus_a.output_data),  32'(vecs[i].dout));
    end

    drive_a(1'b0, 1'b0, 16'h0000, 1'b1); tick_a();
    chk("flush1_used", 32'(bus_a.used_w), 32'd0);

    // fill to full, one dropped write, drain everything
    for (int i = 0; i < 33; i++) begin
      drive_a(1'b1, 1'b0, 16'($urandom_range(0, 65535)), 1'b0);
      tick_a();
      if (i == 31) chk("fill_full_at32", 32'(bus_a.full), 32'd1);
    end
    chk("fill_used64", 32'(bus_a.used_w), 32'd64);
    chk("fill_ovf",    32'(bus_a.overflow), 32'd1);
    for (int i = 0; i < 64; i++) begin
      drive_a(1'b0, 1'b1, 16'h0000, 1'b0);
      tick_a();
    end
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_empty",    32'(bus_a.empty), 32'd1);
    drive_a(1'b0, 1'b0, 16'h0000, 1'b1); tick_a();
    chk("flush_clears_ovf", 32'(bus_a.overflow), 32'd0);

    // underflow: read on empty leaves output_data alone
    held = bus_a.output_data;
    drive_a(1'b0, 1'b1, 16'h0000, 1'b0); tick_a();
    chk("unf_flag",  32'(bus_a.underflow),    32'd1);
    chk("unf_valid", 32'(bus_a.output_valid), 32'd0);
    chk("unf_used",  32'(bus_a.used_w),       32'd0);
    chk("unf_hold",  32'(bus_a.output_data),  32'(held));
    drive_a(1'b0, 1'b0, 16'h0000, 1'b1); tick_a();
    chk("flush_clears_unf", 32'(bus_a.underflow), 32'd0);

    // simultaneous read and write at used_w 4
    drive_a(1'b1, 1'b0, 16'hC3D4, 1'b0); tick_a();
    drive_a(1'b1, 1'b0, 16'hE5F6, 1'b0); tick_a();
    drive_a(1'b1, 1'b1, 16'h1357, 1'b0); tick_a();
    chk("simul_used5", 32'(bus_a.used_w), 32'd5);

    // random streaming of 200 words across several pointer wraps
    accepted = 0;
    cycles   = 0;
    while (accepted < 200 && cycles < 5000) begin
      logic wr, rd;
      wr = ($urandom_range(0, 1) == 1) && (m_used <= 62);
      rd = (m_used > 0) && ($urandom_range(0, 3) != 0);
      drive_a(wr, rd, 16'($urandom_range(0, 65535)), 1'b0);
      if (wr) accepted++;
      tick_a();
      cycles++;
    end
    chk("stream_words", 32'(accepted), 32'd200);
    cycles = 0;
    while (m_used > 0 && cycles < 200) begin
      drive_a(1'b0, 1'b1, 16'h0000, 1'b0);
      tick_a();
      cycles++;
    end
    drive_a(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("stream_no_ovf",   32'(bus_a.overflow), 32'd0);

    // LSB-first, RATIO 4 instance
    tick_b(1'b1, 1'b0, 32'h11223344);
    chk("b_used4", 32'(bus_b.used_w), 32'd4);
    chk("b_empty0", 32'(bus_b.empty), 32'd0);
    tick_b(1'b0, 1'b1, 32'h0);
    chk("b_rd0", 32'(bus_b.output_data), 32'h44);
    chk("b_v0",  32'(bus_b.output_valid), 32'd1);
    tick_b(1'b0, 1'b1, 32'h0);
    chk("b_rd1", 32'(bus_b.output_data), 32'h33);
    tick_b(1'b0, 1'b1, 32'h0);
    chk("b_rd2", 32'(bus_b.output_data), 32'h22);
    tick_b(1'b0, 1'b1, 32'h0);
    chk("b_rd3", 32'(bus_b.output_data), 32'h11);
    chk("b_used0", 32'(bus_b.used_w), 32'd0);
    tick_b(1'b0, 1'b0, 32'h0);
    chk("b_vpulse", 32'(bus_b.output_valid), 32'd0);
    tick_b(1'b1, 1'b0, 32'h55667788);
    tick_b(1'b1, 1'b0, 32'h99AABBCC);
    tick_b(1'b1, 1'b0, 32'hDDEEFF00);
    tick_b(1'b0, 1'b1, 32'h0);
    chk("b_rd4",    32'(bus_b.output_data), 32'h88);
    chk("b_ready",  32'(bus_b.input_ready), 32'd1);

    // asynchronous reset mid-drain
    bus_b.read_req = 1'b1;
    #2 arst = 1'b0;
    #1;
    model_reset();
    chk_reset("mid");
    bus_b.read_req = 1'b0;
    @(posedge clk); #3;
    arst = 1'b1;
    tick_b(1'b1, 1'b0, 32'h01020304);
    chk("b_post_rst_used", 32'(bus_b.used_w), 32'd4);
    tick_b(1'b0, 1'b1, 32'h0);
    chk("b_post_rst_rd", 32'(bus_b.output_data), 32'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
